// File: rtl/frame2bmem.sv
// rtl/frame2bmem.sv - 640x480 gray frame to 28x28 block-average buffer-memory writer (optional FRAME2BMEM_ROUND_EN)
module frame2bmem (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  output logic        oWEN,
  output logic [10:0] oADDR,
  output logic [15:0] oDATA,
  output logic        oDONE
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

  state_t      state_q, state_d;
  logic        fval_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [19:0] acc_q [0:27];
  logic        wen_q, wen_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  avg_q, avg_d;

  logic        sof, pix_ok, in_win, blk_first, blk_last, last_wr, acc_we;
  logic [8:0]  dx, dy;
  logic [4:0]  bx, by;
  logic [19:0] sum_new;
  logic [7:0]  avg_new;

  // Pixel position decode relative to the 448x448 window
  assign sof       = iFVAL & ~fval_q;
  assign pix_ok    = iDVAL & (y_q < 10'd480);
  assign in_win    = (x_q >= 10'd96) && (x_q <= 10'd543) && (y_q >= 10'd16) && (y_q <= 10'd463);
  assign dx        = x_q[8:0] - 9'd96;
  assign dy        = y_q[8:0] - 9'd16;
  assign bx        = dx[8:4];
  assign by        = dy[8:4];
  assign blk_first = (dx[3:0] == 4'h0) && (dy[3:0] == 4'h0);
  assign blk_last  = (dx[3:0] == 4'hF) && (dy[3:0] == 4'hF);
  assign sum_new   = blk_first ? {8'h00, iDATA} : acc_q[bx] + {8'h00, iDATA};
  assign last_wr   = wen_q && (addr_q == 11'd783);
  assign acc_we    = (state_q == CAPTURE) && iFVAL && pix_ok && in_win;

`ifdef FRAME2BMEM_ROUND_EN
  logic [8:0] rnd;
  // Round to nearest, saturating at 255 (only a near-full-scale block can exceed it)
  assign rnd     = 9'((21'(sum_new) + 21'd2048) >> 12);
  assign avg_new = rnd[8] ? 8'hFF : rnd[7:0];
`else
  assign avg_new = sum_new[19:12];
`endif

  // Next-state, pixel counters and write request
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    avg_d   = avg_q;
    case (state_q)
      IDLE: if (iSTART) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (sof) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      CAPTURE: begin
        // The final write wins over a simultaneous end of frame
        if (last_wr) begin
          state_d = DONE;
        end else if (!iFVAL) begin
          state_d = WAIT_SOF;
        end else if (pix_ok) begin
          if (x_q == 10'd639) begin
            x_d = '0;
            y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
          if (in_win && blk_last) begin
            wen_d  = 1'b1;
            addr_d = ({6'd0, by} * 11'd28) + {6'd0, bx};
            avg_d  = avg_new;
          end
        end
      end
      DONE: if (iSTART) state_d = WAIT_SOF;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      fval_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      x_q     <= x_d;
      y_q     <= y_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      avg_q   <= avg_d;
    end
  end

  // Per-column block accumulators: block origin loads, every other window pixel adds
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 28; i++) acc_q[i] <= '0;
    end else if (acc_we) begin
      acc_q[bx] <= sum_new;
    end
  end

  assign oWEN  = wen_q;
  assign oADDR = addr_q;
  assign oDATA = {8'h00, avg_q};
  assign oDONE = (state_q == DONE);

endmodule

// File: tb/tb_frame2bmem.sv
// tb/tb_frame2bmem.sv - randomized frame stimulus against a block-average reference model
module tb_frame2bmem;

  logic        iCLK = 1'b0;
  logic        iRST, iSTART, iFVAL, iDVAL;
  logic [11:0] iDATA;
  logic        oWEN, oDONE;
  logic [10:0] oADDR;
  logic [15:0] oDATA;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wexp = 0;
  int wseen = 0;
  int last_pix_cyc = -1;
  bit armed = 1'b0;
  int msum [784];

  frame2bmem dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iDATA(iDATA), .oWEN(oWEN), .oADDR(oADDR), .oDATA(oDATA), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [15:0] expd(input int s);
`ifdef FRAME2BMEM_ROUND_EN
    int r;
    r = (s + 2048) / 4096;
    if (r > 255) r = 255;
    return 16'(r);
`else
    return 16'(s / 4096);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, step past the edge, score any write
  task automatic pix(input logic dv, input logic [11:0] d, input logic fv, input logic st);
    iDVAL = dv; iDATA = d; iFVAL = fv; iSTART = st;
    @(posedge iCLK);
    #1;
    cyc++;
    if (oWEN) begin
      wseen++;
      if (armed && wexp < 784) begin
        chk("wr_addr", 32'(oADDR), 32'(wexp));
        chk("wr_data", 32'(oDATA), 32'(expd(msum[wexp])));
        if (wexp == 783) chk("last_wr_latency", 32'(cyc), 32'(last_pix_cyc));
        wexp++;
      end
    end
  endtask

  // mode 0 random, 1 single bright pixel at window origin, 2 per-block constant pattern
  task automatic frame(input int mode, input int npix, input int stop_w, input int start_at);
    int x, y, v, idx;
    for (int i = 0; i < 784; i++) msum[i] = 0;
    wexp = 0; wseen = 0; last_pix_cyc = -1;
    pix(1'b0, 12'h0, 1'b0, 1'b0);
    pix(1'b0, 12'h0, 1'b1, 1'b0);
    for (int p = 0; p < npix; p++) begin
      if (stop_w > 0 && wexp >= stop_w) break;
      x = p % 640;
      y = p / 640;
      idx = (x >= 96 && x <= 543 && y >= 16 && y <= 463) ? ((y - 16) / 16) * 28 + (x - 96) / 16 : -1;
      case (mode)
        1:       v = (x == 96 && y == 16) ? 4095 : 0;
        2:       v = (idx >= 0) ? (idx & 12'hFFF) : int'($urandom_range(0, 4095));
        default: v = int'($urandom_range(0, 4095));
      endcase
      if (idx >= 0) msum[idx] += v;
      if (x == 543 && y == 463) last_pix_cyc = cyc + 1;
      pix(1'b1, 12'(v), 1'b1, p == start_at);
    end
  endtask

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
    repeat (3) pix(1'b0, 12'h0, 1'b0, 1'b0);
    chk("rst_wen", 32'(oWEN), 32'd0);
    chk("rst_addr", 32'(oADDR), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    iRST = 1'b0;

    // Not armed: a frame must produce nothing
    frame(0, 32 * 640 + 600, 0, -1);
    chk("idle_writes", 32'(wseen), 32'd0);

    // Arm, single bright pixel at the window origin, abort after first block row
    pix(1'b0, 12'h0, 1'b0, 1'b1);
    armed = 1'b1;
    frame(1, 40 * 640, 28, -1);
    pix(1'b0, 12'h0, 1'b0, 1'b0);
    pix(1'b0, 12'h0, 1'b0, 1'b0);
    chk("abort_writes", 32'(wexp), 32'd28);
    chk("abort_done", 32'(oDONE), 32'd0);

    // Next frame after abort runs to completion with a stray iSTART mid-capture
    frame(0, 463 * 640 + 544, 0, 5000);
    pix(1'b1, 12'h0, 1'b1, 1'b0);
    chk("full_writes", 32'(wexp), 32'd784);
    chk("full_wen_total", 32'(wseen), 32'd784);
    chk("done_set", 32'(oDONE), 32'd1);
    pix(1'b0, 12'h0, 1'b0, 1'b0);
    pix(1'b1, 12'h0, 1'b1, 1'b0);
    chk("done_hold", 32'(oDONE), 32'd1);
    chk("done_no_wen", 32'(oWEN), 32'd0);
    pix(1'b0, 12'h0, 1'b0, 1'b1);
    chk("rearm_done_drop", 32'(oDONE), 32'd0);

    // Block pattern frame interrupted by reset
    frame(2, 48 * 640, 30, -1);
    chk("pattern_writes", 32'(wexp), 32'd30);
    iRST = 1'b1;
    armed = 1'b0;
    #1;
    chk("midrst_wen", 32'(oWEN), 32'd0);
    chk("midrst_addr", 32'(oADDR), 32'd0);
    chk("midrst_data", 32'(oDATA), 32'd0);
    chk("midrst_done", 32'(oDONE), 32'd0);
    pix(1'b1, 12'h5, 1'b1, 1'b0);
    pix(1'b1, 12'h5, 1'b1, 1'b0);
    #2;
    iRST = 1'b0;
    pix(1'b1, 12'h5, 1'b1, 1'b0);

    // After reset, no iSTART: still no writes
    frame(0, 32 * 640 + 600, 0, -1);
    chk("postrst_writes", 32'(wseen), 32'd0);
    chk("postrst_done", 32'(oDONE), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame2bmem.md
FRAME2BMEM -- requirements
Module: frame2bmem

Interface
REQ-001 SHALL have no parameters; all geometry is fixed: 640x480 input, 448x448 window at X=96..543 and Y=16..463, 16x16 blocks, 28x28 output.
REQ-002 SHALL have port iCLK, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port iRST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port iSTART, input, 1, one-cycle arm request.
REQ-005 SHALL have port iFVAL, input, 1, frame valid; its rising edge marks start of frame.
REQ-006 SHALL have port iDVAL, input, 1, pixel valid; 640 pixels per line, raster order.
REQ-007 SHALL have port iDATA, input, 12, gray pixel, sampled when iDVAL=1.
REQ-008 SHALL have port oWEN, output, 1, buffer-memory write enable.
REQ-009 SHALL have port oADDR, output, 11, write address, 0..783.
REQ-010 SHALL have port oDATA, output, 16, write data, {8'h00, avg8}.
REQ-011 SHALL have port oDONE, output, 1, level; 784 samples written.

Function
REQ-012 SHALL implement states IDLE, WAIT_SOF, CAPTURE and DONE.
REQ-013 SHALL move IDLE->WAIT_SOF and DONE->WAIT_SOF on iSTART=1; oDONE SHALL drop in the same cycle the state leaves DONE.
REQ-014 SHALL move WAIT_SOF->CAPTURE on the cycle iFVAL is 1 and was 0 the previous cycle; the pixel counters x and y SHALL be zeroed on entry to CAPTURE.
REQ-015 SHALL, in CAPTURE only, count each iDVAL=1 pixel: x increments and wraps 639->0, y increments on the wrap; pixels with y>=480 SHALL be ignored.
REQ-016 SHALL ignore in-frame pixels outside the window; bx=(x-96)>>4, by=(y-16)>>4, and (x-96)[3:0], (y-16)[3:0] give the in-block position.
REQ-017 SHALL hold 28 accumulators of 20 bits; a window pixel at block position (0,0) SHALL load its accumulator and every other window pixel SHALL add to it; overflow is impossible (256x4095 < 2^20).
REQ-018 SHALL, one cycle after the pixel at block position (15,15) is accepted, assert oWEN for exactly one cycle with oADDR=by*28+bx and oDATA[7:0]=sum[19:12] (avg[11:4]) and oDATA[15:8]=0.
REQ-019 SHALL produce addresses in strictly ascending order, 0..783; the 784th write (oADDR=783) SHALL move CAPTURE->DONE with oDONE=1 in the next cycle.
REQ-020 SHALL, if iFVAL falls in CAPTURE before the 784th write, abort to WAIT_SOF without asserting oDONE; the next frame restarts from address 0.
REQ-021 SHALL ignore iSTART while in WAIT_SOF or CAPTURE.
REQ-022 SHALL keep oWEN=0 outside CAPTURE, except for the final write cycle of REQ-019.
REQ-023 SHALL ignore iDVAL and iFVAL edges while in IDLE and DONE.

Reset
REQ-024 SHALL, on iRST=1 at any time (mid-frame included), immediately force state IDLE, oWEN=0, oADDR=0, oDATA=0, oDONE=0, zero x, y and all accumulators, and clear the iFVAL edge register.
REQ-025 SHALL restart cleanly after iRST falls: no write until a new iSTART and a new rising edge of iFVAL.

Configuration
REQ-026 SHALL, with FRAME2BMEM_ROUND_EN defined, set oDATA[7:0] to min(255, (sum+2048)>>12), rounding to nearest with saturation.
REQ-027 SHALL, without FRAME2BMEM_ROUND_EN, set oDATA[7:0] to sum[19:12], truncating; latency and handshakes are identical in both builds.

Verification
REQ-028 SHALL verify a flat frame: iSTART, then one full frame of iDATA=12'hABC -> 784 writes, addresses 0..783 in order, all oDATA=16'h00AB, then oDONE=1.
REQ-029 SHALL verify window edges: a frame of 0 except pixel (96,16)=4095 -> oADDR 0 oDATA=16'h0000 untruncated (sum 4095); in a ROUND_EN build oDATA=16'h0001.
REQ-030 SHALL verify a block pattern: pixel value=(bx+28*by)&0xFFF replicated per block -> write k has oDATA[7:0]=(k&0xFFF)>>4, and oWEN follows pixel (543,463) by exactly 1 cycle.
REQ-031 SHALL verify abort: iFVAL falls after 400 writes -> state WAIT_SOF, oDONE stays 0, and the next full frame writes addresses 0..783.
REQ-032 SHALL verify reset: iRST pulse after 100 writes -> all outputs 0, state IDLE; a frame with no iSTART gives no writes.
REQ-033 SHALL verify re-arm: in DONE, iSTART -> oDONE=0 next cycle; iSTART during CAPTURE has no effect on the write count.
